// File: rtl/alu_ctrl16.sv
// Register-file controller that feeds an external combinational ALU and writes its result back.
// Optional macro ALU_CTRL_NOWB_EN adds cmd_nowb: a command that updates the flags only.
module alu_ctrl16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [2:0]  cmd_dst,
  input  logic [2:0]  cmd_srcR,
  input  logic [2:0]  cmd_srcS,
`ifdef ALU_CTRL_NOWB_EN
  input  logic        cmd_nowb,
`endif
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic [15:0] R,
  output logic [15:0] S,
  output logic [3:0]  Alu_op,
  input  logic [15:0] Y,
  input  logic        N,
  input  logic        Z,
  input  logic        C,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];
  logic [15:0] r_q, r_d;
  logic [15:0] s_q, s_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  dst_q, dst_d;
  logic        nowb_q, nowb_d;
  logic        flag_n_q, flag_n_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_c_q, flag_c_d;
  logic        done_q, done_d;
  logic        accept_s;
  logic        nowb_in_s;

`ifdef ALU_CTRL_NOWB_EN
  assign nowb_in_s = cmd_nowb;
`else
  assign nowb_in_s = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE) && !wr_en;
  assign accept_s  = cmd_valid && cmd_ready;
  assign rd_data   = regs_q[rd_addr];
  assign R         = r_q;
  assign S         = s_q;
  assign Alu_op    = op_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign done      = done_q;

  // Next-state: host writes and command accept only in IDLE; write-back on EXEC -> WB.
  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    r_d      = r_q;
    s_d      = s_q;
    op_d     = op_q;
    dst_d    = dst_q;
    nowb_d   = nowb_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          regs_d[wr_addr] = wr_data;
        end else if (accept_s) begin
          // Sources are sampled here, so a later write to the same index cannot leak in.
          r_d     = regs_q[cmd_srcR];
          s_d     = regs_q[cmd_srcS];
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          nowb_d  = nowb_in_s;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (!nowb_q) begin
          regs_d[dst_q] = Y;
        end else begin
          regs_d[dst_q] = regs_q[dst_q];
        end
        flag_n_d = N;
        flag_z_d = Z;
        flag_c_d = C;
        done_d   = 1'b1;
        state_d  = WB;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
      r_q      <= 16'h0000;
      s_q      <= 16'h0000;
      op_q     <= 4'b0000;
      dst_q    <= 3'd0;
      nowb_q   <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      r_q      <= r_d;
      s_q      <= s_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      nowb_q   <= nowb_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl16.sv
// Directed bench for alu_ctrl16 with a small external ALU model driving Y/N/Z/C.
module tb_alu_ctrl16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_dst, cmd_srcR, cmd_srcS;
  logic        cmd_nowb;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] R, S, Y;
  logic [3:0]  Alu_op;
  logic        N, Z, C;
  logic        flag_n, flag_z, flag_c, done;
  logic [16:0] y17;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accepts = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int done_gap = 0;
  int acc0, done0;

  alu_ctrl16 dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srcR(cmd_srcR), .cmd_srcS(cmd_srcS),
`ifdef ALU_CTRL_NOWB_EN
    .cmd_nowb(cmd_nowb),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .R(R), .S(S), .Alu_op(Alu_op), .Y(Y), .N(N), .Z(Z), .C(C),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .done(done)
  );

  always #5 clk = ~clk;

  // External ALU: 0001 AND, 0010 S+1, 0100 ADD, 0101 SUB (C=borrow), 1011 XOR, else OR.
  always_comb begin
    case (Alu_op)
      4'b0001: y17 = {1'b0, R & S};
      4'b0010: y17 = {1'b0, S} + 17'd1;
      4'b0100: y17 = {1'b0, R} + {1'b0, S};
      4'b0101: y17 = {1'b0, R} - {1'b0, S};
      4'b1011: y17 = {1'b0, R ^ S};
      default: y17 = {1'b0, R | S};
    endcase
    Y = y17[15:0];
    C = y17[16];
    N = y17[15];
    Z = (y17[15:0] == 16'h0000);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && cmd_valid && cmd_ready) accepts <= accepts + 1;
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      done_gap      <= cyc - last_done_cyc;
      last_done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] sr, input logic [2:0] ss);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srcR = sr; cmd_srcS = ss;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    rd_addr = a;
    #1;
    chk(tag, {16'h0000, rd_data}, {16'h0000, exp});
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'b0000; cmd_dst = 3'd0;
    cmd_srcR = 3'd0; cmd_srcS = 3'd0; cmd_nowb = 1'b0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000; rd_addr = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_R", {16'h0, R}, 32'h0);
    chk("rst_S", {16'h0, S}, 32'h0);
    chk("rst_op", {28'h0, Alu_op}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_flags", {29'h0, flag_n, flag_z, flag_c}, 32'h0);
    rd_chk("rst_r3", 3'd3, 16'h0000);
    reset = 1'b0;
    #2;
    chk("ready_idle", {31'h0, cmd_ready}, 32'h1);

    // Add: r3 = r1 + r2
    wr_en = 1'b1; #1;
    chk("ready_wr", {31'h0, cmd_ready}, 32'h0);
    wr_en = 1'b0;
    host_wr(3'd1, 16'h1234);
    host_wr(3'd2, 16'h0001);
    rd_chk("wr_r1", 3'd1, 16'h1234);
    issue(4'b0100, 3'd3, 3'd1, 3'd2);
    chk("add_R", {16'h0, R}, 32'h1234);
    chk("add_S", {16'h0, S}, 32'h0001);
    chk("add_op", {28'h0, Alu_op}, 32'h4);
    chk("add_exec_done", {31'h0, done}, 32'h0);
    chk("add_exec_ready", {31'h0, cmd_ready}, 32'h0);
    step();
    chk("add_done", {31'h0, done}, 32'h1);
    rd_chk("add_r3", 3'd3, 16'h1235);
    chk("add_flags", {29'h0, flag_n, flag_z, flag_c}, 32'h0);
    step();
    chk("add_done_low", {31'h0, done}, 32'h0);
    chk("add_ready", {31'h0, cmd_ready}, 32'h1);

    // Sub to zero: r4 = r1 - r1
    host_wr(3'd1, 16'h0005);
    issue(4'b0101, 3'd4, 3'd1, 3'd1);
    step();
    rd_chk("sub_r4", 3'd4, 16'h0000);
    chk("sub_z", {31'h0, flag_z}, 32'h1);
    chk("sub_n", {31'h0, flag_n}, 32'h0);
    step();

    // Increment with overflow, destination equals source
    host_wr(3'd5, 16'hFFFF);
    issue(4'b0010, 3'd5, 3'd0, 3'd5);
    chk("inc_S_prewrite", {16'h0, S}, 32'hFFFF);
    step();
    rd_chk("inc_r5", 3'd5, 16'h0000);
    chk("inc_c", {31'h0, flag_c}, 32'h1);
    chk("inc_z", {31'h0, flag_z}, 32'h1);
    step();

    // Back-to-back: valid held 6 cycles, host write attempted during EXEC
    acc0 = accepts; done0 = done_cnt;
    cmd_valid = 1'b1; cmd_op = 4'b0001; cmd_dst = 3'd6; cmd_srcR = 3'd1; cmd_srcS = 3'd2;
    step();
    cmd_op = 4'b1011; cmd_dst = 3'd7;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
    step();
    wr_en = 1'b0;
    repeat (4) step();
    cmd_valid = 1'b0;
    step();
    chk("b2b_accepts", accepts - acc0, 32'd2);
    chk("b2b_dones", done_cnt - done0, 32'd2);
    chk("b2b_gap", done_gap, 32'd3);
    rd_chk("b2b_r2_kept", 3'd2, 16'h0001);
    rd_chk("b2b_r6_and", 3'd6, 16'h0001);
    rd_chk("b2b_r7_xor", 3'd7, 16'h0004);

    // Reset during EXEC aborts the command
    done0 = done_cnt;
    issue(4'b0100, 3'd6, 3'd1, 3'd2);
    #2 reset = 1'b1;
    #1;
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_R", {16'h0, R}, 32'h0);
    step();
    reset = 1'b0;
    repeat (2) step();
    rd_chk("abort_r6", 3'd6, 16'h0000);
    chk("abort_flags", {29'h0, flag_n, flag_z, flag_c}, 32'h0);
    chk("abort_no_done", done_cnt - done0, 32'd0);
    chk("abort_ready", {31'h0, cmd_ready}, 32'h1);

`ifdef ALU_CTRL_NOWB_EN
    // Flags-only command leaves the destination untouched
    done0 = done_cnt;
    host_wr(3'd7, 16'h00AA);
    cmd_nowb = 1'b1;
    issue(4'b0101, 3'd7, 3'd7, 3'd7);
    cmd_nowb = 1'b0;
    step();
    chk("nowb_z", {31'h0, flag_z}, 32'h1);
    rd_chk("nowb_r7", 3'd7, 16'h00AA);
    step();
    step();
    chk("nowb_done", done_cnt - done0, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl16.md
ALU_CTRL16 -- requirements
Module: alu_ctrl16

Interface
REQ-001 Parameters: none; register file fixed at 8 x 16 bits.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_op  input  4  ALU opcode forwarded unchanged to Alu_op.
REQ-007 cmd_dst / cmd_srcR / cmd_srcS  input  3 each  destination, R-source and S-source register indices.
REQ-008 wr_en / wr_addr / wr_data  input  1/3/16  host register write port.
REQ-009 rd_addr  input  3; rd_data  output  16  combinational register read, rd_data = regs[rd_addr].
REQ-010 R, S  output  16 each  registered operands to the ALU.
REQ-011 Alu_op  output  4  registered opcode to the ALU.
REQ-012 Y  input  16; N, Z, C  input  1 each  combinational ALU result and flags.
REQ-013 flag_n, flag_z, flag_c  output  1 each  registered status flags.
REQ-014 done  output  1  one-cycle pulse on command completion.

Function
REQ-015 FSM states: IDLE, EXEC, WB; encoding free.
REQ-016 cmd_ready = 1 only in IDLE with wr_en = 0.
REQ-017 Host write: in IDLE with wr_en = 1, regs[wr_addr] <= wr_data at the edge; no command accepted that cycle.
REQ-018 wr_en outside IDLE is ignored; no register changes.
REQ-019 Accept: at the edge where cmd_valid && cmd_ready, R <= regs[cmd_srcR], S <= regs[cmd_srcS], Alu_op <= cmd_op, dst latched, IDLE -> EXEC.
REQ-020 EXEC -> WB unconditionally; at that edge regs[dst] <= Y, flag_n <= N, flag_z <= Z, flag_c <= C.
REQ-021 WB: done = 1 for exactly that cycle; WB -> IDLE unconditionally.
REQ-022 Latency: accept edge to done high = 2 edges; max throughput 1 command per 3 cycles.
REQ-023 cmd_valid while not in IDLE is ignored; command is not latched or queued.
REQ-024 cmd_dst equal to a source index: source read at accept edge uses pre-write value.
REQ-025 R, S, Alu_op hold last values outside accept edges; flags hold until next EXEC -> WB edge.
REQ-026 Opcode values are not decoded; every 4-bit value, including undefined ones, is forwarded and its ALU output written back.
REQ-027 rd_data reflects a write-back in the cycle after the writing edge (i.e. during WB).

Reset
REQ-028 reset asserted: state <= IDLE, all 8 registers <= 16'h0000, R = S = 16'h0000, Alu_op = 4'b0000, flags = 0, done = 0, immediately and asynchronously.
REQ-029 Reset during EXEC or WB aborts the command: no write-back, no flag update, no done pulse.
REQ-030 First command accepted on the first rising edge with reset low and cmd_valid high.

Configuration
REQ-031 Macro ALU_CTRL_NOWB_EN defined: extra input cmd_nowb (1 bit) latched at accept; if 1, EXEC -> WB updates flags only, regs unchanged, done still pulses.
REQ-032 ALU_CTRL_NOWB_EN undefined: port cmd_nowb absent; every command writes back per REQ-020.

Verification
REQ-033 Reset, write r1 = 16'h1234, r2 = 16'h0001, cmd op 0100 dst r3 srcR r1 srcS r2 -> R = 1234, S = 0001, Alu_op = 0100 in EXEC; done in WB; r3 = 16'h1235; N = 0, Z = 0, C = 0.
REQ-034 r1 = 16'h0005, op 0101 dst r4 srcR r1 srcS r1 -> r4 = 16'h0000, flag_z = 1, flag_n = 0.
REQ-035 r5 = 16'hFFFF, op 0010 dst r5 srcS r5 -> r5 = 16'h0000, flag_c = 1, flag_z = 1; source read is pre-write value.
REQ-036 cmd_valid held high for 6 cycles, cmd ops 0001 then 1011 -> exactly 2 accepts, done pulses 3 cycles apart; wr_en = 1 during EXEC -> target register unchanged.
REQ-037 Assert reset during EXEC of op 0100 dst r6 -> r6 = 0, flags = 0, no done, state IDLE, cmd_ready = 1 after release.
REQ-038 With ALU_CTRL_NOWB_EN: r7 = 16'h00AA, cmd_nowb = 1, op 0101 dst r7 srcR r7 srcS r7 -> flag_z = 1, r7 stays 16'h00AA, done pulses once.
